// File: rtl/imem_axi_rd_slave.sv
// AXI4 read-only slave (AR/R channels) backed by a 64-bit word array, used to refill an I-cache.
// Supports programmable first-beat latency, INCR/WRAP/FIXED bursts and a byte-masked side write port.
module imem_axi_rd_slave #(
   parameter int unsigned ADDR_W    = 64,
   parameter int unsigned MEM_WORDS = 1024,
   parameter logic [63:0] BASE      = 64'h8000_0000,
   parameter int unsigned LAT       = 2,
   parameter int unsigned ID_W      = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         ar_valid,
   output logic                         ar_ready,
   input  logic [ADDR_W-1:0]            ar_addr,
   input  logic [ID_W-1:0]              ar_id,
   input  logic [7:0]                   ar_len,
   input  logic [2:0]                   ar_size,
   input  logic [1:0]                   ar_burst,
   output logic                         r_valid,
   input  logic                         r_ready,
   output logic [63:0]                  r_data,
   output logic [1:0]                   r_resp,
   output logic                         r_last,
   output logic [ID_W-1:0]              r_id,
   input  logic                         mw_en,
   input  logic [$clog2(MEM_WORDS)-1:0] mw_idx,
   input  logic [63:0]                  mw_data,
   input  logic [7:0]                   mw_strb
);

   localparam int unsigned       IDX_W     = $clog2(MEM_WORDS);
   localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(BASE);
   localparam logic [ADDR_W-1:0] MEM_BYTES = ADDR_W'(MEM_WORDS) << 3;
   localparam logic [3:0]        LAT_C     = 4'(LAT);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_BEAT = 2'd2
   } state_t;

   function automatic logic [ADDR_W-1:0] step_f(input logic [2:0] size);
      step_f = ADDR_W'(1) << size;
   endfunction

   function automatic logic slverr_f(input logic [ADDR_W-1:0] addr, input logic [7:0] len,
                                     input logic [2:0] size, input logic [1:0] burst);
      logic wrap_bad;
      logic misalign;
      wrap_bad = (burst == 2'b10) &&
                 !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
      misalign = (burst != 2'b00) && ((addr & (step_f(size) - ADDR_W'(1))) != ADDR_W'(0));
      slverr_f = wrap_bad || misalign;
   endfunction

   function automatic logic decerr_f(input logic [ADDR_W-1:0] addr);
      decerr_f = (addr < BASE_A) || ((addr - BASE_A) >= MEM_BYTES);
   endfunction

   // Reserved burst encoding 2'b11 falls into the INCR default.
   function automatic logic [ADDR_W-1:0] next_addr_f(input logic [ADDR_W-1:0] addr, input logic [7:0] len,
                                                     input logic [2:0] size, input logic [1:0] burst);
      logic [ADDR_W-1:0] step;
      logic [ADDR_W-1:0] bmask;
      step  = step_f(size);
      bmask = ((ADDR_W'(len) + ADDR_W'(1)) * step) - ADDR_W'(1);
      case (burst)
         2'b00:   next_addr_f = addr;
         2'b10:   next_addr_f = (addr & ~bmask) | ((addr + step) & bmask);
         default: next_addr_f = addr + step;
      endcase
   endfunction

   logic [63:0]       mem_r [MEM_WORDS];
   state_t            state_r, state_nxt;
   logic              ar_ready_r, r_valid_r, r_last_r, slverr_r;
   logic [63:0]       r_data_r;
   logic [1:0]        r_resp_r;
   logic [ID_W-1:0]   r_id_r, id_r, ld_id_s;
   logic [ADDR_W-1:0] addr_r, ld_addr_s, ld_off_s;
   logic [7:0]        len_r, beat_r, ld_beat_s, ld_len_s;
   logic [2:0]        size_r;
   logic [1:0]        burst_r;
   logic [3:0]        wait_r;
   logic              latch_s, load_s, finish_s, ld_slverr_s, ld_dec_s;
   logic [IDX_W-1:0]  ld_idx_s;
   logic [63:0]       ld_word_s;

   assign ld_off_s  = ld_addr_s - BASE_A;
   assign ld_idx_s  = IDX_W'(ld_off_s >> 3);
   assign ld_word_s = mem_r[ld_idx_s];
   assign ld_dec_s  = decerr_f(ld_addr_s);

   // Next-state and beat-load selection; the load path always names the address of the beat being presented next.
   always_comb begin
      state_nxt   = state_r;
      latch_s     = 1'b0;
      load_s      = 1'b0;
      finish_s    = 1'b0;
      ld_addr_s   = addr_r;
      ld_slverr_s = slverr_r;
      ld_beat_s   = beat_r;
      ld_len_s    = len_r;
      ld_id_s     = id_r;
      case (state_r)
         ST_IDLE: begin
            if (ar_valid && ar_ready_r) begin
               latch_s     = 1'b1;
               ld_addr_s   = ar_addr;
               ld_slverr_s = slverr_f(ar_addr, ar_len, ar_size, ar_burst);
               ld_beat_s   = 8'd0;
               ld_len_s    = ar_len;
               ld_id_s     = ar_id;
               if (LAT_C == 4'd0) begin
                  state_nxt = ST_BEAT;
                  load_s    = 1'b1;
               end else begin
                  state_nxt = ST_WAIT;
               end
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (wait_r <= 4'd1) begin
               state_nxt = ST_BEAT;
               load_s    = 1'b1;
            end else begin
               state_nxt = ST_WAIT;
            end
         end
         ST_BEAT: begin
            if (r_valid_r && r_ready) begin
               if (beat_r == len_r) begin
                  state_nxt = ST_IDLE;
                  finish_s  = 1'b1;
               end else begin
                  load_s    = 1'b1;
                  ld_addr_s = next_addr_f(addr_r, len_r, size_r, burst_r);
                  ld_beat_s = beat_r + 8'd1;
               end
            end else begin
               state_nxt = ST_BEAT;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // State, request latch and registered R-channel outputs; outputs only change on a load or burst end.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r    <= ST_IDLE;
         ar_ready_r <= 1'b1;
         r_valid_r  <= 1'b0;
         r_last_r   <= 1'b0;
         r_data_r   <= 64'd0;
         r_resp_r   <= 2'b00;
         r_id_r     <= {ID_W{1'b0}};
         addr_r     <= {ADDR_W{1'b0}};
         id_r       <= {ID_W{1'b0}};
         len_r      <= 8'd0;
         size_r     <= 3'd0;
         burst_r    <= 2'b00;
         beat_r     <= 8'd0;
         wait_r     <= 4'd0;
         slverr_r   <= 1'b0;
      end else begin
         state_r    <= state_nxt;
         ar_ready_r <= (state_nxt == ST_IDLE);
         if (latch_s) begin
            addr_r   <= ar_addr;
            id_r     <= ar_id;
            len_r    <= ar_len;
            size_r   <= ar_size;
            burst_r  <= ar_burst;
            beat_r   <= 8'd0;
            wait_r   <= LAT_C;
            slverr_r <= ld_slverr_s;
         end else if (state_r == ST_WAIT) begin
            wait_r <= wait_r - 4'd1;
         end
         if (load_s) begin
            addr_r    <= ld_addr_s;
            beat_r    <= ld_beat_s;
            r_valid_r <= 1'b1;
            r_last_r  <= (ld_beat_s == ld_len_s);
            r_id_r    <= ld_id_s;
            if (ld_slverr_s) begin
               r_resp_r <= 2'b10;
               r_data_r <= 64'd0;
            end else if (ld_dec_s) begin
               r_resp_r <= 2'b11;
               r_data_r <= 64'd0;
            end else begin
               r_resp_r <= 2'b00;
               r_data_r <= ld_word_s;
            end
         end else if (finish_s) begin
            r_valid_r <= 1'b0;
            r_last_r  <= 1'b0;
         end
      end
   end

   // Byte-masked array write; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (mw_en) begin
         for (int b = 0; b < 8; b++) begin
            if (mw_strb[b]) begin
               mem_r[mw_idx][b*8 +: 8] <= mw_data[b*8 +: 8];
            end
         end
      end
   end

   assign ar_ready = ar_ready_r;
   assign r_valid  = r_valid_r;
   assign r_last   = r_last_r;
   assign r_data   = r_data_r;
   assign r_resp   = r_resp_r;
   assign r_id     = r_id_r;

endmodule

// File: tb/tb_imem_axi_rd_slave.sv
// Scoreboard bench for imem_axi_rd_slave: instance A uses LAT=2, instance B uses LAT=0.
// Stimulus pushes hand-computed beats into per-instance queues; negedge monitors pop and compare.
module tb_imem_axi_rd_slave;
   localparam logic [63:0] BASE = 64'h8000_0000;
   localparam logic [1:0]  OK = 2'b00, SLV = 2'b10, DEC = 2'b11;

   typedef struct packed {
      logic [63:0] data;
      logic [1:0]  resp;
      logic        last;
      logic [3:0]  id;
   } beat_t;

   logic clk = 1'b0;
   logic rst;
   logic a_ar_valid, a_ar_ready, a_r_valid, a_r_ready, a_r_last;
   logic [63:0] a_ar_addr, a_r_data;
   logic [3:0]  a_ar_id, a_r_id;
   logic [7:0]  a_ar_len;
   logic [2:0]  a_ar_size;
   logic [1:0]  a_ar_burst, a_r_resp;
   logic b_ar_valid, b_ar_ready, b_r_valid, b_r_ready, b_r_last;
   logic [63:0] b_ar_addr, b_r_data;
   logic [3:0]  b_ar_id, b_r_id;
   logic [7:0]  b_ar_len;
   logic [2:0]  b_ar_size;
   logic [1:0]  b_ar_burst, b_r_resp;
   logic        mw_en;
   logic [9:0]  mw_idx;
   logic [63:0] mw_data;
   logic [7:0]  mw_strb;

   beat_t sb_a[$];
   beat_t sb_b[$];
   int    b_times[$];
   int    tests = 0;
   int    fails = 0;
   int    cyc = 0;
   int    rdy_mode = 0;
   int    rdy_ph = 0;
   logic  a_held = 1'b0, a_after = 1'b0;
   beat_t a_hold, a_e, b_e;

   imem_axi_rd_slave #(.LAT(2)) dut_a (
      .clk(clk), .rst(rst),
      .ar_valid(a_ar_valid), .ar_ready(a_ar_ready), .ar_addr(a_ar_addr), .ar_id(a_ar_id),
      .ar_len(a_ar_len), .ar_size(a_ar_size), .ar_burst(a_ar_burst),
      .r_valid(a_r_valid), .r_ready(a_r_ready), .r_data(a_r_data), .r_resp(a_r_resp),
      .r_last(a_r_last), .r_id(a_r_id),
      .mw_en(mw_en), .mw_idx(mw_idx), .mw_data(mw_data), .mw_strb(mw_strb));

   imem_axi_rd_slave #(.LAT(0)) dut_b (
      .clk(clk), .rst(rst),
      .ar_valid(b_ar_valid), .ar_ready(b_ar_ready), .ar_addr(b_ar_addr), .ar_id(b_ar_id),
      .ar_len(b_ar_len), .ar_size(b_ar_size), .ar_burst(b_ar_burst),
      .r_valid(b_r_valid), .r_ready(b_r_ready), .r_data(b_r_data), .r_resp(b_r_resp),
      .r_last(b_r_last), .r_id(b_r_id),
      .mw_en(mw_en), .mw_idx(mw_idx), .mw_data(mw_data), .mw_strb(mw_strb));

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      tests++;
      fails++;
      $display("FAIL %s: bound expired or unexpected event", name);
   endtask

   task automatic push(input bit sel, input logic [63:0] data, input logic [1:0] resp,
                       input logic last, input logic [3:0] id);
      beat_t e;
      e.data = data; e.resp = resp; e.last = last; e.id = id;
      if (sel) sb_b.push_back(e);
      else     sb_a.push_back(e);
   endtask

   task automatic mw_write(input logic [9:0] idx, input logic [63:0] data, input logic [7:0] strb);
      @(negedge clk);
      mw_en = 1'b1; mw_idx = idx; mw_data = data; mw_strb = strb;
      @(negedge clk);
      mw_en = 1'b0;
   endtask

   // Returns cycles from the handshake cycle to the first cycle with r_valid high.
   task automatic issue(input bit sel, input logic [63:0] addr, input logic [3:0] id, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst, output int lat);
      int n;
      n = 0;
      @(negedge clk);
      if (sel) begin
         b_ar_addr = addr; b_ar_id = id; b_ar_len = len; b_ar_size = size; b_ar_burst = burst; b_ar_valid = 1'b1;
      end else begin
         a_ar_addr = addr; a_ar_id = id; a_ar_len = len; a_ar_size = size; a_ar_burst = burst; a_ar_valid = 1'b1;
      end
      while (!(sel ? b_ar_ready : a_ar_ready) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) fail_now("ar_ready_timeout");
      @(posedge clk);
      #1;
      if (sel) b_ar_valid = 1'b0;
      else     a_ar_valid = 1'b0;
      lat = 1;
      while (!(sel ? b_r_valid : a_r_valid) && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic wait_done(input bit sel);
      int n;
      n = 0;
      while (((sel ? sb_b.size() : sb_a.size()) != 0) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) begin
         fail_now(sel ? "b_drain" : "a_drain");
         sb_a.delete();
         sb_b.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   // r_ready driver for instance A: 0 = always ready, 1 = 1,0,0 repeating, other = held low.
   initial begin
      a_r_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0: a_r_ready = 1'b1;
            1: begin
               a_r_ready = (rdy_ph == 0);
               rdy_ph = (rdy_ph == 2) ? 0 : rdy_ph + 1;
            end
            default: a_r_ready = 1'b0;
         endcase
      end
   end

   // Instance A monitor: stall stability plus in-order scoreboard compare on each handshake.
   always @(negedge clk) begin
      if (a_after) begin
         a_after = 1'b0;
         chk("a_ar_ready_after_last", a_ar_ready, 1'b1);
         chk("a_r_valid_after_last", a_r_valid, 1'b0);
      end
      if (rst && a_r_valid) begin
         if (a_held) begin
            chk("a_stall_data", a_r_data, a_hold.data);
            chk("a_stall_resp", a_r_resp, a_hold.resp);
            chk("a_stall_last", a_r_last, a_hold.last);
         end
         if (a_r_ready) begin
            a_held = 1'b0;
            if (sb_a.size() == 0) fail_now("a_unexpected_beat");
            else begin
               a_e = sb_a.pop_front();
               chk("a_data", a_r_data, a_e.data);
               chk("a_resp", a_r_resp, a_e.resp);
               chk("a_last", a_r_last, a_e.last);
               chk("a_id", a_r_id, a_e.id);
               a_after = a_e.last;
            end
         end else begin
            a_held = 1'b1;
            a_hold.data = a_r_data; a_hold.resp = a_r_resp; a_hold.last = a_r_last; a_hold.id = a_r_id;
         end
      end else begin
         a_held = 1'b0;
      end
   end

   // Instance B monitor: scoreboard compare and beat timestamps.
   always @(negedge clk) begin
      if (rst && b_r_valid && b_r_ready) begin
         b_times.push_back(cyc);
         if (sb_b.size() == 0) fail_now("b_unexpected_beat");
         else begin
            b_e = sb_b.pop_front();
            chk("b_data", b_r_data, b_e.data);
            chk("b_resp", b_r_resp, b_e.resp);
            chk("b_last", b_r_last, b_e.last);
            chk("b_id", b_r_id, b_e.id);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int n;
      rst = 1'b0;
      a_ar_valid = 1'b0; a_ar_addr = 64'd0; a_ar_id = 4'd0; a_ar_len = 8'd0; a_ar_size = 3'd0; a_ar_burst = 2'b00;
      b_ar_valid = 1'b0; b_ar_addr = 64'd0; b_ar_id = 4'd0; b_ar_len = 8'd0; b_ar_size = 3'd0; b_ar_burst = 2'b00;
      b_r_ready = 1'b1;
      mw_en = 1'b0; mw_idx = 10'd0; mw_data = 64'd0; mw_strb = 8'd0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_ar_ready", a_ar_ready, 1'b1);
      chk("rst_r_valid", a_r_valid, 1'b0);
      chk("rst_r_last", a_r_last, 1'b0);
      chk("rst_r_data", a_r_data, 64'd0);
      chk("rst_r_resp", a_r_resp, 2'b00);
      chk("rst_r_id", a_r_id, 4'd0);

      for (int i = 0; i < 8; i++) mw_write(10'(i), 64'h1000 + 64'(i), 8'hFF);
      mw_write(10'd1023, 64'hABCD, 8'hFF);

      // INCR critical path, LAT=2
      for (int i = 0; i < 4; i++) push(1'b0, 64'h1002 + 64'(i), OK, i == 3, 4'd5);
      issue(1'b0, BASE + 64'h10, 4'd5, 8'd3, 3'd3, 2'b01, lat);
      chk("a_first_latency", 64'(lat), 64'd3);
      wait_done(1'b0);

      // WRAP critical-word-first
      push(1'b0, 64'h1003, OK, 1'b0, 4'd3);
      push(1'b0, 64'h1000, OK, 1'b0, 4'd3);
      push(1'b0, 64'h1001, OK, 1'b0, 4'd3);
      push(1'b0, 64'h1002, OK, 1'b1, 4'd3);
      issue(1'b0, BASE + 64'h18, 4'd3, 8'd3, 3'd3, 2'b10, lat);
      wait_done(1'b0);

      // Backpressure with a write to the presented word during the stall
      rdy_mode = 2;
      for (int i = 0; i < 4; i++) push(1'b0, 64'h1002 + 64'(i), OK, i == 3, 4'd6);
      issue(1'b0, BASE + 64'h10, 4'd6, 8'd3, 3'd3, 2'b01, lat);
      mw_write(10'd2, 64'hDEAD_BEEF_0000_0000, 8'hF0);
      repeat (2) @(negedge clk);
      rdy_ph = 0;
      rdy_mode = 1;
      wait_done(1'b0);
      rdy_mode = 0;
      push(1'b0, 64'hDEAD_BEEF_0000_1002, OK, 1'b1, 4'd7);
      issue(1'b0, BASE + 64'h10, 4'd7, 8'd0, 3'd3, 2'b00, lat);
      wait_done(1'b0);
      mw_write(10'd2, 64'h1002, 8'hFF);

      // Top-of-array crossing
      push(1'b0, 64'hABCD, OK, 1'b0, 4'd1);
      push(1'b0, 64'd0, DEC, 1'b1, 4'd1);
      issue(1'b0, BASE + 64'h1FF8, 4'd1, 8'd1, 3'd3, 2'b01, lat);
      wait_done(1'b0);

      // WRAP with illegal length
      for (int i = 0; i < 3; i++) push(1'b0, 64'd0, SLV, i == 2, 4'd2);
      issue(1'b0, BASE, 4'd2, 8'd2, 3'd3, 2'b10, lat);
      wait_done(1'b0);

      // Below BASE
      push(1'b0, 64'd0, DEC, 1'b0, 4'd4);
      push(1'b0, 64'd0, DEC, 1'b1, 4'd4);
      issue(1'b0, 64'h0, 4'd4, 8'd1, 3'd3, 2'b01, lat);
      wait_done(1'b0);

      // Misaligned INCR, narrow INCR, reserved burst
      push(1'b0, 64'd0, SLV, 1'b1, 4'd8);
      issue(1'b0, BASE + 64'h4, 4'd8, 8'd0, 3'd3, 2'b01, lat);
      wait_done(1'b0);
      push(1'b0, 64'h1001, OK, 1'b0, 4'd10);
      push(1'b0, 64'h1001, OK, 1'b0, 4'd10);
      push(1'b0, 64'h1002, OK, 1'b0, 4'd10);
      push(1'b0, 64'h1002, OK, 1'b1, 4'd10);
      issue(1'b0, BASE + 64'h8, 4'd10, 8'd3, 3'd2, 2'b01, lat);
      wait_done(1'b0);
      push(1'b0, 64'h1004, OK, 1'b0, 4'd11);
      push(1'b0, 64'h1005, OK, 1'b1, 4'd11);
      issue(1'b0, BASE + 64'h20, 4'd11, 8'd1, 3'd3, 2'b11, lat);
      wait_done(1'b0);

      // Reset while beat 2 of an 8-beat burst is presented
      for (int i = 0; i < 8; i++) push(1'b0, 64'h1000 + 64'(i), OK, i == 7, 4'd9);
      issue(1'b0, BASE, 4'd9, 8'd7, 3'd3, 2'b01, lat);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("midrst_r_valid", a_r_valid, 1'b0);
      chk("midrst_ar_ready", a_ar_ready, 1'b1);
      chk("midrst_r_last", a_r_last, 1'b0);
      chk("midrst_r_data", a_r_data, 64'd0);
      chk("midrst_pending", 64'(sb_a.size()), 64'd6);
      sb_a.delete();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      push(1'b0, 64'h1006, OK, 1'b0, 4'd12);
      push(1'b0, 64'h1007, OK, 1'b1, 4'd12);
      issue(1'b0, BASE + 64'h30, 4'd12, 8'd1, 3'd3, 2'b01, lat);
      wait_done(1'b0);

      // LAT=0 instance: latency and back-to-back spacing
      push(1'b1, 64'h1001, OK, 1'b1, 4'd1);
      issue(1'b1, BASE + 64'h8, 4'd1, 8'd0, 3'd3, 2'b01, lat);
      chk("b_first_latency", 64'(lat), 64'd1);
      wait_done(1'b1);
      b_times.delete();
      push(1'b1, 64'h1002, OK, 1'b1, 4'd2);
      push(1'b1, 64'h1003, OK, 1'b1, 4'd3);
      @(negedge clk);
      b_ar_addr = BASE + 64'h10; b_ar_id = 4'd2; b_ar_len = 8'd0; b_ar_size = 3'd3; b_ar_burst = 2'b01;
      b_ar_valid = 1'b1;
      @(posedge clk);
      #1;
      b_ar_addr = BASE + 64'h18; b_ar_id = 4'd3;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!b_ar_ready && n < 20);
      if (n >= 20) fail_now("b_b2b_ready");
      @(posedge clk);
      #1;
      b_ar_valid = 1'b0;
      wait_done(1'b1);
      if (b_times.size() < 2) fail_now("b_b2b_beats");
      else chk("b_b2b_spacing", 64'(b_times[1] - b_times[0]), 64'd2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
